// File: rtl/ss_display_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment display controller.
// Provides mode encodings, the hex glyph table and the blank/all-on patterns.
// Segment patterns are {dp,g,f,e,d,c,b,a}, active-low.
package ss_display_pkg;

   localparam logic [1:0] MODE_HEX   = 2'd0;
   localparam logic [1:0] MODE_BLANK = 2'd1;
   localparam logic [1:0] MODE_TEST  = 2'd2;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_ALL   = 8'h00;

   // Hex glyphs 0..F, dp segment off.
   localparam logic [7:0] SEG_GLYPH [0:15] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

endpackage

// File: rtl/ss_display_ctrl_if.sv
// Bus between the CSR wiring and the display controller / board pins.
// Ports: value/dp/load/mode/lzb_en/brightness inputs toward the controller,
//        ss_anodes/ss_segments/pending/frame_tick outputs from it.
interface ss_display_ctrl_if #(
   parameter int NUM_DIGITS   = 4,
   parameter int BRIGHT_WIDTH = 4
);
   logic [4*NUM_DIGITS-1:0] value_i;
   logic [NUM_DIGITS-1:0]   dp_i;
   logic                    load_i;
   logic [1:0]              mode_i;
   logic                    lzb_en_i;
   logic [BRIGHT_WIDTH-1:0] brightness_i;
   logic [NUM_DIGITS-1:0]   ss_anodes_o;
   logic [7:0]              ss_segments_o;
   logic                    pending_o;
   logic                    frame_tick_o;

   modport master (
      output value_i, dp_i, load_i, mode_i, lzb_en_i, brightness_i,
      input  ss_anodes_o, ss_segments_o, pending_o, frame_tick_o
   );

   modport slave (
      input  value_i, dp_i, load_i, mode_i, lzb_en_i, brightness_i,
      output ss_anodes_o, ss_segments_o, pending_o, frame_tick_o
   );
endinterface

// File: rtl/ss_display_ctrl_glyph_decoder.sv
// Combinational nibble + dp + blank -> active-low segment pattern.
// Ports: nibble_i (hex digit), dp_i (decimal point), blank_i (force all off),
//        seg_o ({dp,g,f,e,d,c,b,a}, active-low).
module ss_glyph_decoder (
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);
   import ss_display_pkg::*;

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         seg_o = SEG_GLYPH[nibble_i];
         if (dp_i) seg_o[7] = 1'b0;
      end
   end
endmodule

// File: rtl/ss_display_ctrl.sv
// Multiplexed seven-segment scanner with frame-aligned double buffer, PWM brightness,
// leading-zero blanking and blank/test modes. Pins are registered (1 cycle after counters).
// Ports: clk_i, rst_i (async, active-high), bus (slave side of ss_display_ctrl_if).
module ss_display_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BRIGHT_WIDTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   ss_display_ctrl_if.slave  bus
);
   import ss_display_pkg::*;

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int DW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

   logic [PW-1:0]           presc_q, presc_d;
   logic [DW-1:0]           digit_q, digit_d;
   logic [BRIGHT_WIDTH-1:0] pwm_q, pwm_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic                    pending_q, pending_d;
   logic                    tick_q, tick_d;
   logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
   logic [7:0]              segs_q, segs_d;

   logic                    slot_end, frame_end;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    lead_zero;
   logic [7:0]              glyph;
   logic                    pwm_on;

   // Counters and double buffer.
   always_comb begin
      slot_end   = (presc_q == PRESC_LAST);
      frame_end  = slot_end && (digit_q == DIGIT_LAST);
      presc_d    = slot_end ? '0 : presc_q + 1'b1;
      digit_d    = digit_q;
      if (slot_end) digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
      pwm_d      = pwm_q + 1'b1;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pending_d  = pending_q;
      tick_d     = frame_end;
      // The boundary transfers what was already pending; a load in the same
      // cycle refills pending and keeps the flag up for the next frame.
      if (frame_end && pending_q) begin
         disp_val_d = pend_val_q;
         disp_dp_d  = pend_dp_q;
      end
      if (frame_end) pending_d = 1'b0;
      if (bus.load_i) begin
         pend_val_d = bus.value_i;
         pend_dp_d  = bus.dp_i;
         pending_d  = 1'b1;
      end
   end

   // Leading zeros: walk from the top digit down until a non-zero nibble.
   always_comb begin
      blank_mask = '0;
      lead_zero  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         lead_zero     = lead_zero && (disp_val_q[4*k +: 4] == 4'h0);
         blank_mask[k] = bus.lzb_en_i && lead_zero;
      end
   end

   ss_glyph_decoder u_dec (
      .nibble_i (disp_val_q[{digit_q, 2'b00} +: 4]),
      .dp_i     (disp_dp_q[digit_q]),
      .blank_i  (blank_mask[digit_q]),
      .seg_o    (glyph)
   );

   // Output pins; prescaler 0 is a dark gap so the previous digit never ghosts.
   always_comb begin
      pwm_on   = (pwm_q < bus.brightness_i) || (&bus.brightness_i);
      anodes_d = '1;
      segs_d   = SEG_BLANK;
      case (bus.mode_i)
         MODE_HEX:  segs_d = glyph;
         MODE_TEST: segs_d = SEG_ALL;
         default:   segs_d = SEG_BLANK;
      endcase
      if ((bus.mode_i == MODE_HEX || bus.mode_i == MODE_TEST) &&
          (presc_q != '0) && pwm_on)
         anodes_d[digit_q] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q    <= '0;
         digit_q    <= '0;
         pwm_q      <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
         pending_q  <= 1'b0;
         tick_q     <= 1'b0;
         anodes_q   <= '1;
         segs_q     <= SEG_BLANK;
      end else begin
         presc_q    <= presc_d;
         digit_q    <= digit_d;
         pwm_q      <= pwm_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         pending_q  <= pending_d;
         tick_q     <= tick_d;
         anodes_q   <= anodes_d;
         segs_q     <= segs_d;
      end
   end

   assign bus.ss_anodes_o   = anodes_q;
   assign bus.ss_segments_o = segs_q;
   assign bus.pending_o     = pending_q;
   assign bus.frame_tick_o  = tick_q;
endmodule
